// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control-unit to datapath signal bundle
interface multicycle_control_unit_if #(
   parameter int NREGS = 8,
   parameter int IR_W  = 9,
   parameter int CNT_W = 16
);
   logic             run;
   logic [IR_W-1:0]  ir;
   logic             irin;
   logic [NREGS-1:0] rin;
   logic [NREGS-1:0] rout;
   logic             dinout;
   logic             gout;
   logic             ain;
   logic             gin;
   logic [2:0]       aluop;
   logic             done;
   logic [2:0]       tstep;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  run, ir,
      output irin, rin, rout, dinout, gout, ain, gin, aluop, done, tstep, instr_count
   );

   modport slave (
      output run, ir,
      input  irin, rin, rout, dinout, gout, ain, gin, aluop, done, tstep, instr_count
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - T0..T3 sequencer and decoder for the 16-bit multicycle CPU
module multicycle_control_unit #(
   parameter int NREGS = 8,
   parameter int IR_W  = 9,
   parameter int CNT_W = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   multicycle_control_unit_if.master    ctrl
);
   typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_e;

   tstep_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [2:0]       op, rx, ry;
   logic [NREGS-1:0] oh_x, oh_y;

   logic             irin, dinout, gout, ain, gin, done;
   logic [NREGS-1:0] rin, rout;
   logic [2:0]       aluop;

   assign op   = ctrl.ir[IR_W-1 -: 3];
   assign rx   = ctrl.ir[5:3];
   assign ry   = ctrl.ir[2:0];
   assign oh_x = NREGS'(1) << rx;
   assign oh_y = NREGS'(1) << ry;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= T0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      irin    = 1'b0;
      rin     = '0;
      rout    = '0;
      dinout  = 1'b0;
      gout    = 1'b0;
      ain     = 1'b0;
      gin     = 1'b0;
      aluop   = 3'b000;
      done    = 1'b0;
      unique case (state_q)
         T0: begin
            irin = ctrl.run;
            if (ctrl.run) state_d = T1;
         end
         T1: begin
            unique case (op)
               3'b000: begin
                  rout    = oh_y;
                  rin     = oh_x;
                  done    = 1'b1;
                  state_d = T0;
               end
               3'b001: begin
                  dinout  = 1'b1;
                  rin     = oh_x;
                  done    = 1'b1;
                  state_d = T0;
               end
               default: begin
                  // A captures Rx now so Ry may reuse the bus next step, even when X=Y
                  rout    = oh_x;
                  ain     = 1'b1;
                  state_d = T2;
               end
            endcase
         end
         T2: begin
            rout    = oh_y;
            gin     = 1'b1;
            aluop   = (op[2:1] != 2'b00) ? op : 3'b000;
            state_d = T3;
         end
         T3: begin
            gout    = 1'b1;
            rin     = oh_x;
            done    = 1'b1;
            state_d = T0;
         end
         default: state_d = T0;
      endcase
   end

   assign cnt_d = done ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         bus_exclusive: assert ($onehot0({rout, dinout, gout}) && $onehot0(rin));
      end
   end

   assign ctrl.irin        = irin;
   assign ctrl.rin         = rin;
   assign ctrl.rout        = rout;
   assign ctrl.dinout      = dinout;
   assign ctrl.gout        = gout;
   assign ctrl.ain         = ain;
   assign ctrl.gin         = gin;
   assign ctrl.aluop       = aluop;
   assign ctrl.done        = done;
   assign ctrl.tstep       = {1'b0, state_q};
   assign ctrl.instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;
   typedef struct packed {
      logic [2:0]  tstep;
      logic        irin;
      logic [7:0]  rin;
      logic [7:0]  rout;
      logic        dinout;
      logic        gout;
      logic        ain;
      logic        gin;
      logic [2:0]  aluop;
      logic        done;
      logic [15:0] cnt;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [8:0] ir  = '0;

   int   n_vec  = 0;
   int   n_miss = 0;
   bit   sb_en  = 1'b0;
   int   retired = 0;
   vec_t exp_q[$];

   multicycle_control_unit_if #(.NREGS(8), .IR_W(9), .CNT_W(16)) bif ();
   multicycle_control_unit_if #(.NREGS(8), .IR_W(9), .CNT_W(4))  aif ();

   assign bif.run = run;
   assign bif.ir  = ir;
   assign aif.run = run;
   assign aif.ir  = ir;

   multicycle_control_unit #(.NREGS(8), .IR_W(9), .CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .ctrl(bif.master));
   multicycle_control_unit #(.NREGS(8), .IR_W(9), .CNT_W(4)) dut_small (
      .clk_i(clk), .rst_i(rst), .ctrl(aif.master));

   always #5 clk = ~clk;

   function automatic vec_t blank(input int step);
      vec_t v;
      v       = '0;
      v.tstep = 3'(step);
      v.cnt   = 16'(retired);
      return v;
   endfunction

   function automatic vec_t actual();
      vec_t v;
      v.tstep  = bif.tstep;
      v.irin   = bif.irin;
      v.rin    = bif.rin;
      v.rout   = bif.rout;
      v.dinout = bif.dinout;
      v.gout   = bif.gout;
      v.ain    = bif.ain;
      v.gin    = bif.gin;
      v.aluop  = bif.aluop;
      v.done   = bif.done;
      v.cnt    = bif.instr_count;
      return v;
   endfunction

   // Reference: the cycle-by-cycle bus plan of one instruction, straight from the opcode table
   task automatic push_instr(input int op, input int x, input int y);
      vec_t v;
      v = blank(0); v.irin = 1'b1; exp_q.push_back(v);
      if (op == 0 || op == 1) begin
         v = blank(1);
         v.rin  = 8'(1 << x);
         v.done = 1'b1;
         if (op == 0) v.rout = 8'(1 << y);
         else         v.dinout = 1'b1;
         exp_q.push_back(v);
      end else begin
         v = blank(1); v.rout = 8'(1 << x); v.ain = 1'b1; exp_q.push_back(v);
         v = blank(2); v.rout = 8'(1 << y); v.gin = 1'b1; v.aluop = 3'(op); exp_q.push_back(v);
         v = blank(3); v.gout = 1'b1; v.rin = 8'(1 << x); v.done = 1'b1; exp_q.push_back(v);
      end
      retired = (retired + 1) % 65536;
   endtask

   // Called at posedge+1 with the DUT in T0; returns at posedge+1 back in T0
   task automatic do_instr(input int op, input int x, input int y, input bit drop);
      int lat;
      lat = (op < 2) ? 2 : 4;
      run = 1'b1;
      ir  = {3'(op), 3'(x), 3'(y)};
      push_instr(op, x, y);
      @(posedge clk); #1;
      if (drop) run = 1'b0;
      repeat (lat - 1) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      run = 1'b0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(blank(0));
         @(posedge clk); #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (sb_en) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL sb_underflow: DUT presented tstep %0d with no expected vector", bif.tstep);
         end else begin
            vec_t e, a;
            e = exp_q.pop_front();
            a = actual();
            if (a !== e || aif.instr_count !== e.cnt[3:0]) begin
               n_miss++;
               $display("FAIL cycle_vec: got %h (small cnt %h) expected %h (small cnt %h)",
                        a, aif.instr_count, e, e.cnt[3:0]);
            end
         end
      end
   end

   initial begin
      int op, x, y;
      // Reset mid-T2 of add R1,R2 with the scoreboard off, then check the async clear
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      run = 1'b1; ir = 9'b010_001_010;
      repeat (2) @(posedge clk);
      #1 check("pre_reset_tstep", 32'(bif.tstep), 32'd2);
      #1 rst = 1'b1; run = 1'b0;
      #1 check("async_reset_tstep", 32'(bif.tstep), 32'd0);
      check("async_reset_outputs",
            32'({bif.irin, bif.rin, bif.rout, bif.dinout, bif.gout, bif.ain, bif.gin, bif.aluop, bif.done}),
            32'd0);
      check("async_reset_count", 32'(bif.instr_count), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      sb_en = 1'b1;
      idle(5);

      // mvi R3 then mv R5,R3 back-to-back with Run held
      do_instr(1, 3, 0, 1'b0);
      do_instr(0, 5, 3, 1'b0);
      check("count_after_two", 32'(bif.instr_count), 32'd2);
      idle(1);
      do_instr(2, 1, 2, 1'b0);
      do_instr(3, 0, 7, 1'b1);
      idle(3);

      // Every opcode with boundary and aliased register pairs
      for (int o = 0; o < 8; o++) begin
         do_instr(o, 0, 7, 1'b0);
         do_instr(o, 7, 0, 1'b1);
         x = $urandom_range(0, 7);
         do_instr(o, x, x, 1'b0);
         idle(1);
      end

      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 7);
         x  = $urandom_range(0, 7);
         y  = $urandom_range(0, 7);
         do_instr(op, x, y, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(2);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      sb_en = 1'b0;
      check("final_count", 32'(bif.instr_count), 32'(retired));
      check("final_small_count", 32'(aif.instr_count), 32'(retired % 16));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequencing FSM for the 16-bit multicycle processor.
- Steps the datapath through Tstep T0..T3 and decodes the 9-bit instruction word (III XXX YYY).
- Drives the register-file load/drive enables, bus mux selects, A/G register loads and the ALU operation code; pulses Done at instruction completion.
- Sits between the board top level (Run, manual Clock, Reset switches) and the datapath. Its Tstep output feeds the step display.

Parameters:
- NREGS, 8, number of general registers; Rin/Rout one-hot width.
- IR_W, 9, instruction width: opcode[8:6], Rx[5:3], Ry[2:0].
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock; on the board this is the debounced manual key.
- Reset  in  1  asynchronous, active-high reset.
- Run  in  1  start request, level-sensitive, sampled only in T0.
- IR  in  IR_W  current instruction word from the datapath IR register.
- IRin  out  1  load IR from DIN.
- Rin  out  NREGS  one-hot register load enable.
- Rout  out  NREGS  one-hot register bus drive.
- DINout  out  1  DIN drives the bus.
- Gout  out  1  G drives the bus.
- Ain  out  1  load A from the bus.
- Gin  out  1  load G from the ALU.
- ALUop  out  3  ALU operation.
- Done  out  1  final step of an instruction.
- Tstep  out  3  current step: 0..3.
- InstrCount  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, any cycle, including mid-instruction):
  - Tstep=0, InstrCount=0; all control outputs 0 while Run=0.
  - No Done is emitted for an aborted instruction.
- State and outputs:
  - Tstep is the registered state.
  - Control outputs are combinational from Tstep, IR and (in T0 only) Run. They are valid for the whole cycle; the datapath loads on the next rising Clock.
- Opcodes:
  - 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 slt, 110 sll, 111 srl.
  - ALUop = opcode[2:0] for 010..111; ALUop = 000 otherwise.
- T0:
  - IRin=Run.
  - If Run=1, go to T1; otherwise stay in T0.
- T1:
  - mv: Rout[Y]=1, Rin[X]=1, Done=1, go to T0.
  - mvi: DINout=1, Rin[X]=1, Done=1, go to T0. The immediate is taken from DIN during this cycle.
  - ALU ops: Rout[X]=1, Ain=1, go to T2.
- T2 (ALU ops): Rout[Y]=1, Gin=1, ALUop valid, go to T3.
- T3 (ALU ops): Gout=1, Rin[X]=1, Done=1, go to T0.
- Bus exclusivity:
  - At most one of Rout bits, DINout, Gout is high in any cycle.
  - At most one Rin bit is high.
  - Violation is a design error; add an assertion.
- X=Y is legal, e.g. add R2,R2 doubles R2. A is loaded in T1 before the bus is reused in T2.
- Run changes outside T0 are ignored; the instruction always completes.
- Run held high after Done: the next instruction is fetched in the following T0 cycle.
- Done:
  - High for exactly one cycle per instruction.
  - InstrCount increments on the rising edge that ends a Done cycle.
  - InstrCount wraps from 2^CNT_W-1 to 0.
- Latency (fetch cycle included): mv/mvi 2 cycles; ALU ops 4 cycles.
- Unknown or X on IR is not possible: all 8 opcodes are defined.

Test Plan:
- Reset then idle: Reset=1 mid-T2 of an add, then release with Run=0 -> Tstep=0 immediately (async), all outputs 0, InstrCount=0, Tstep stays 0 over 5 clocks.
- mvi then mv: Run=1, IR=001_011_000 -> T0 IRin=1; T1 DINout=1, Rin=00001000, Done=1. Then IR=000_101_011 -> T1 Rout=00001000, Rin=00100000, Done=1. InstrCount=2.
- add R1,R2: IR=010_001_010 -> T1 Rout=00000010, Ain=1; T2 Rout=00000100, Gin=1, ALUop=010; T3 Gout=1, Rin=00000010, Done=1. Tstep sequence 0,1,2,3,0.
- Run dropped mid-instruction: sub IR=011_000_111, Run deasserted in T1 -> T2 and T3 still execute, ALUop=011, Done in T3. Then remain in T0 with IRin=0.
- Exclusivity sweep: all 8 opcodes × X,Y ∈ {0,7,X=Y} -> assertion never fires. ALU ops take exactly 4 cycles and mv/mvi exactly 2, with one Done each.
- Counter wrap: force InstrCount to 16'hFFFF, run one mv -> InstrCount=16'h0000.
